aditya_patra: RTL and testbench
===============================

# aditya_patra

Three-channel sensor alarm controller. Samples three asynchronous sensor inputs, selects the highest-priority active sensor, and drives the matching buzzer with a square-wave tone while that sensor stays active. It sits between raw sensor pads and buzzer drivers, and only one buzzer sounds at a time.

## Interface
- TONE_HALF_PERIOD, default 4: buzzer high/low half-period in clock cycles, ≥1; tone period is 2×TONE_HALF_PERIOD cycles.
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- sensor1  input  1  sensor 1 request, active-high, asynchronous; lowest priority.
- sensor2  input  1  sensor 2 request, active-high, asynchronous; middle priority.
- sensor3  input  1  sensor 3 request, active-high, asynchronous; highest priority.
- buzzer1  output  1  tone output for sensor 1, registered.
- buzzer2  output  1  tone output for sensor 2, registered.
- buzzer3  output  1  tone output for sensor 3, registered.

## Operation
- Reset (reset=0): state IDLE, buzzer1/2/3=0, tone counter=0, synchronizer flops=0. Takes effect immediately, independent of clk.
- States: IDLE, ALERT1, ALERT2, ALERT3.
- Each rising edge: next state = ALERT3 if s3, else ALERT2 if s2, else ALERT1 if s1, else IDLE. Here s1–s3 are the synchronized sensors.
- Entering ALERTn from any other state:
  - Tone counter clears to 0.
  - buzzern=1 on that same edge; all other buzzers=0.
- Remaining in ALERTn:
  - Counter increments each cycle.
  - When the counter reaches TONE_HALF_PERIOD-1, it wraps to 0 and buzzern toggles.
- Entering IDLE: all buzzers=0 and counter=0 on that edge.
- Simultaneous sensors: only the highest-priority buzzer sounds. Lower-priority sensors are ignored until it releases.
- Priority handoff (e.g. sensor3 drops while sensor2 held): immediate switch to ALERT2. The new tone starts high from a fresh counter.
- Invariant: at most one buzzer is high in any cycle.

## Timing
- With synchronizer: edge E1 is the first rising edge that samples a sensor high. The FSM and buzzer update at E3 (3-cycle latency). Release has the same latency.
- Without synchronizer: FSM and buzzer update at E1.
- Tone: in steady ALERTn, buzzern is high for TONE_HALF_PERIOD cycles, then low for TONE_HALF_PERIOD cycles, repeating.
- Default tone: 4 high / 4 low, 80 ns period at 100 MHz.
- Sensor pulses narrower than one clock may be missed. This is acceptable.
- Reset deassertion: the first state update occurs on the first rising edge after reset returns to 1.

## Configuration
- SENSOR_SYNC_EN defined: each sensor passes through a 2-flop synchronizer, giving 3-cycle latency.
- SENSOR_SYNC_EN undefined: sensors feed the priority logic directly, giving 1-cycle latency. Use only when inputs are already synchronous to clk.
- Default build defines SENSOR_SYNC_EN.

## Structure
- Package aditya_patra_pkg:
  - State enum: IDLE=2'd0, ALERT1=2'd1, ALERT2=2'd2, ALERT3=2'd3.
  - Default TONE_HALF_PERIOD constant.
  - Counter width, derived as $clog2(TONE_HALF_PERIOD) with a minimum of 1.
- Sub-module aditya_patra_sync: a 2-flop synchronizer with async active-low reset, instantiated once per sensor under SENSOR_SYNC_EN.
- The top level holds the priority encoder, the state register, the tone counter and the output registers.

## Test plan
- Reset: hold reset=0 for 2 cycles with all sensors high. All buzzers stay 0, and the state is IDLE until reset=1.
- Single sensor: sensor1=1 for 10 cycles after reset.
  - buzzer1 rises at E3, high for 4 cycles, low for 4, then high again.
  - buzzer1 returns to 0 three cycles after sensor1 falls.
  - buzzer2 and buzzer3 stay 0 throughout.
- Each channel: repeat the single-sensor case for sensor2 and for sensor3. The same pattern appears on buzzer2 and buzzer3 respectively.
- Priority: sensor2 and sensor3 high together for 40 cycles.
  - Only buzzer3 toggles, with period 8.
  - buzzer2 is 0 throughout.
- Handoff: with sensor2 still high, drop sensor3.
  - Three cycles later buzzer3=0 and buzzer2=1 on the same edge.
  - buzzer2 then toggles from a fresh half-period.
- Reset mid-alarm: pull reset=0 while buzzer1 is high. buzzer1 goes 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/aditya_patra_pkg.sv
// Shared types and constants for the aditya_patra sensor alarm controller.
// The sensor synchronizers are built only when SENSOR_SYNC_EN is defined.
package aditya_patra_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALERT1 = 2'd1,
    ALERT2 = 2'd2,
    ALERT3 = 2'd3
  } state_t;

  localparam int unsigned TONE_HALF_PERIOD_DEF = 4;

  function automatic int unsigned cnt_width(input int unsigned half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(TONE_HALF_PERIOD_DEF);

  // Buzzer vector {buzzer3, buzzer2, buzzer1} that belongs to an alert state.
  function automatic logic [2:0] buzz_sel(input state_t s);
    logic [2:0] r;
    r = '0;
    case (s)
      ALERT1:  r = 3'b001;
      ALERT2:  r = 3'b010;
      ALERT3:  r = 3'b100;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aditya_patra_sync.sv
// Two-flop synchronizer for one asynchronous sensor input.
module aditya_patra_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aditya_patra.sv
// Three-channel priority sensor alarm with square-wave buzzer tones.
// Define SENSOR_SYNC_EN to pass each sensor through a 2-flop synchronizer.
module aditya_patra
  import aditya_patra_pkg::*;
#(
  parameter int unsigned TONE_HALF_PERIOD = TONE_HALF_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor1,
  input  logic sensor2,
  input  logic sensor3,
  output logic buzzer1,
  output logic buzzer2,
  output logic buzzer3
);

  localparam int unsigned CW = cnt_width(TONE_HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(TONE_HALF_PERIOD - 1);

  logic s1, s2, s3;

`ifdef SENSOR_SYNC_EN
  aditya_patra_sync u_sync1 (.clk(clk), .reset(reset), .d(sensor1), .q(s1));
  aditya_patra_sync u_sync2 (.clk(clk), .reset(reset), .d(sensor2), .q(s2));
  aditya_patra_sync u_sync3 (.clk(clk), .reset(reset), .d(sensor3), .q(s3));
`else
  assign s1 = sensor1;
  assign s2 = sensor2;
  assign s3 = sensor3;
`endif

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      buzz;

  always_comb begin
    nxt = IDLE;
    if (s3)      nxt = ALERT3;
    else if (s2) nxt = ALERT2;
    else if (s1) nxt = ALERT1;
  end

  // A change of alert state restarts the tone high from a fresh counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      buzz  <= '0;
    end else begin
      state <= nxt;
      if (nxt == IDLE) begin
        cnt  <= '0;
        buzz <= '0;
      end else if (nxt != state) begin
        cnt  <= '0;
        buzz <= buzz_sel(nxt);
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        buzz <= buzz ^ buzz_sel(nxt);
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

  assign buzzer1 = buzz[0];
  assign buzzer2 = buzz[1];
  assign buzzer3 = buzz[2];

endmodule

// File: tb/tb_aditya_patra.sv
// Self-checking bench for aditya_patra: behavioural tone model plus directed pins.
module tb_aditya_patra;

  localparam int THP = 4;
`ifdef SENSOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor1 = 1'b0, sensor2 = 1'b0, sensor3 = 1'b0;
  logic buzzer1, buzzer2, buzzer3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aditya_patra #(.TONE_HALF_PERIOD(THP)) dut (
    .clk(clk), .reset(reset),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
    .buzzer1(buzzer1), .buzzer2(buzzer2), .buzzer3(buzzer3)
  );

  logic [2:0] bz, cur, eff, expv;
  assign bz  = {buzzer3, buzzer2, buzzer1};
  assign cur = {sensor3, sensor2, sensor1};

  // Model: sensor samples delayed by the input latency, active channel and its age.
  logic [2:0] p1, p2;
  int mchan, age;
  assign eff = (LAT == 3) ? p2 : cur;

  function automatic int chan_of(input logic [2:0] v);
    if (v[2]) return 3;
    if (v[1]) return 2;
    if (v[0]) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1 <= '0; p2 <= '0; mchan <= 0; age <= 0;
    end else begin
      p1 <= cur;
      p2 <= p1;
      mchan <= chan_of(eff);
      age <= (chan_of(eff) != mchan) ? 0 : age + 1;
    end
  end

  always_comb begin
    expv = '0;
    if (mchan != 0 && ((age / THP) % 2) == 0) expv = 3'b001 << (mchan - 1);
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: buzzers=%b expected=%b at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model", bz, expv);
    checks++;
    if ($countones(bz) > 1) begin
      errors++;
      $display("FAIL onehot: buzzers=%b expected at most one high at %0t", bz, $time);
    end
  end

  task automatic single(input int ch);
    logic [2:0] oh;
    oh = 3'b001 << (ch - 1);
    @(negedge clk) {sensor3, sensor2, sensor1} = oh;
    repeat (LAT) @(posedge clk);
    #1 chk($sformatf("ch%0d_rise", ch), bz, oh);
    repeat (3) @(posedge clk);
    #1 chk($sformatf("ch%0d_high4", ch), bz, oh);
    @(posedge clk);
    #1 chk($sformatf("ch%0d_low", ch), bz, 3'b000);
    repeat (3) @(posedge clk);
    #1 chk($sformatf("ch%0d_low4", ch), bz, 3'b000);
    @(posedge clk);
    #1 chk($sformatf("ch%0d_rehigh", ch), bz, oh);
    @(negedge clk) {sensor3, sensor2, sensor1} = 3'b000;
    repeat (LAT) @(posedge clk);
    #1 chk($sformatf("ch%0d_release", ch), bz, 3'b000);
    repeat (4) @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) {sensor3, sensor2, sensor1} = 3'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    {sensor3, sensor2, sensor1} = 3'b111;
    repeat (2) @(negedge clk);
    chk("reset_hold", bz, 3'b000);
    {sensor3, sensor2, sensor1} = 3'b000;
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int ch = 1; ch <= 3; ch++) single(ch);

    @(negedge clk) {sensor3, sensor2, sensor1} = 3'b110;
    repeat (LAT) @(posedge clk);
    #1 chk("prio_rise", bz, 3'b100);
    repeat (40) @(negedge clk);

    {sensor3, sensor2, sensor1} = 3'b010;
    repeat (LAT) @(posedge clk);
    #1 chk("handoff", bz, 3'b010);
    repeat (4) @(posedge clk);
    #1 chk("handoff_low", bz, 3'b000);
    repeat (4) @(posedge clk);
    #1 chk("handoff_rehigh", bz, 3'b010);
    @(negedge clk) {sensor3, sensor2, sensor1} = 3'b000;
    repeat (6) @(negedge clk);

    random_phase(400);

    @(negedge clk) {sensor3, sensor2, sensor1} = 3'b000;
    repeat (6) @(negedge clk);
    {sensor3, sensor2, sensor1} = 3'b001;
    repeat (LAT) @(posedge clk);
    #1 chk("pre_reset", bz, 3'b001);
    #2 reset = 1'b0;
    #1 chk("async_reset", bz, 3'b000);
    repeat (2) @(negedge clk);
    {sensor3, sensor2, sensor1} = 3'b000;
    reset = 1'b1;

    random_phase(200);
    @(negedge clk) {sensor3, sensor2, sensor1} = 3'b000;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
